// File: rtl/vblnk_write_arbiter.sv
// Round-robin arbiter sharing one frame-buffer write port between N_REQ drawing
// masters; writes are only granted while the display is in vertical blanking.
module vblnk_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 12,
    parameter int MAX_BURST = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vblnk,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        last,
    input  logic [N_REQ*ADDR_W-1:0] addr_in,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        gnt,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    frame_start,
    output logic                    busy
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]  sel, sel_nxt, cand;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic              vblnk_d;
    logic              found, beat, burst_end;
    logic [N_REQ-1:0]  gnt_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [DATA_W-1:0] wr_data_nxt;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Scan from the far end back toward rr_ptr so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        cand  = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                cand  = wrap_add(rr_ptr, k);
            end
        end
    end

    // Any non-beat cycle in GRANT means req dropped or blanking ended.
    assign beat      = (state == GRANT) && req[sel] && vblnk;
    assign burst_end = (state == GRANT) && (!beat || last[sel] || beat_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sel         <= '0;
            beat_cnt    <= '0;
            vblnk_d     <= 1'b0;
            gnt         <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            sel         <= sel_nxt;
            beat_cnt    <= beat_cnt_nxt;
            vblnk_d     <= vblnk;
            gnt         <= gnt_nxt;
            wr_en       <= wr_en_nxt;
            wr_addr     <= wr_addr_nxt;
            wr_data     <= wr_data_nxt;
            frame_start <= vblnk & ~vblnk_d;
            busy        <= (state_nxt == GRANT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vblnk) state_nxt = ARB;
            ARB: begin
                if (!vblnk)     state_nxt = IDLE;
                else if (found) state_nxt = GRANT;
            end
            GRANT:   if (burst_end) state_nxt = vblnk ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt      = gnt;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        beat_cnt_nxt = beat_cnt;
        rr_ptr_nxt   = rr_ptr;
        sel_nxt      = sel;
        case (state)
            IDLE: gnt_nxt = '0;
            ARB: begin
                gnt_nxt = '0;
                if (vblnk && found) begin
                    gnt_nxt      = N_REQ'(1) << cand;
                    sel_nxt      = cand;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    wr_en_nxt    = 1'b1;
                    wr_addr_nxt  = addr_in[int'(sel) * ADDR_W +: ADDR_W];
                    wr_data_nxt  = data_in[int'(sel) * DATA_W +: DATA_W];
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
                if (burst_end) begin
                    gnt_nxt    = '0;
                    rr_ptr_nxt = wrap_add(sel, 1);
                end
            end
            default: gnt_nxt = '0;
        endcase
    end
endmodule
